// File: rtl/core_pkg.sv
// Shared definitions for the RV32 multi-cycle core: sequencer states,
// the canonical NOP encoding and the major opcodes used by the decoder.
package core_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    function automatic logic word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM: owns the shared memory port, PC, IR and MDR,
// and steps each instruction through fetch, decode, execute, memory and writeback.
module core_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_req,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic               mem_ready,
    input  logic [31:0]        mem_rdata,
    output logic [31:0]        instr,
    input  logic               dec_wb,
    input  logic               dec_mem,
    input  logic               dec_mem_read,
    input  logic               dec_branch,
    input  logic               dec_illegal,
    input  logic signed [31:0] imm,
    input  logic [31:0]        alu_result,
    input  logic [31:0]        rb_data,
    input  logic               branch_taken,
    output logic               rf_we,
    output logic [31:0]        rf_wdata,
    output logic [31:0]        pc,
    output logic               retire,
    output logic               halted
);

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] mdr_q;
    logic        halted_q;

    logic [31:0] pc_seq;
    logic [31:0] br_target;
    logic        br_ok;

    // Both sums wrap mod 2^32; the signed offset handles backward branches.
    assign pc_seq    = pc_q + 32'd4;
    assign br_target = branch_taken ? (pc_q + $unsigned(imm)) : pc_seq;
    assign br_ok     = word_aligned(br_target);

    // Outputs are pure decodes of the state and held registers; rst masks
    // every strobe so a pending transaction is dropped in the reset cycle.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = 32'd0;
        rf_we     = 1'b0;
        rf_wdata  = 32'd0;
        retire    = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                end
                EXECUTE: begin
                    retire = dec_branch && br_ok;
                end
                MEM: begin
                    mem_req   = 1'b1;
                    mem_we    = !dec_mem_read;
                    mem_addr  = alu_result;
                    mem_wdata = rb_data;
                    retire    = !dec_mem_read && mem_ready;
                end
                WRITEBACK: begin
                    rf_we    = dec_wb;
                    rf_wdata = dec_mem_read ? mdr_q : alu_result;
                    retire   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign instr  = ir_q;
    assign pc     = pc_q;
    assign halted = halted_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= NOP;
            mdr_q    <= 32'd0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        ir_q  <= mem_rdata;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (dec_illegal) begin
                        state    <= HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state <= EXECUTE;
                    end
                end
                EXECUTE: begin
                    if (dec_branch) begin
                        // A misaligned target stops the core with the PC of the branch.
                        if (br_ok) begin
                            pc_q  <= br_target;
                            state <= FETCH;
                        end else begin
                            state    <= HALT;
                            halted_q <= 1'b1;
                        end
                    end else if (dec_mem) begin
                        state <= MEM;
                    end else begin
                        state <= WRITEBACK;
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        if (dec_mem_read) begin
                            mdr_q <= mem_rdata;
                            state <= WRITEBACK;
                        end else begin
                            pc_q  <= pc_seq;
                            state <= FETCH;
                        end
                    end
                end
                WRITEBACK: begin
                    pc_q  <= pc_seq;
                    state <= FETCH;
                end
                HALT: begin
                    state    <= HALT;
                    halted_q <= 1'b1;
                end
                default: begin
                    state    <= HALT;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: a table-driven memory/decoder model,
// directed programs, and a negedge monitor that pops expected events.
module tb_core_sequencer;
    import core_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               mem_req, mem_we, mem_ready;
    logic [31:0]        mem_addr, mem_wdata, mem_rdata, instr;
    logic               dec_wb, dec_mem, dec_mem_read, dec_branch, dec_illegal;
    logic signed [31:0] imm;
    logic [31:0]        alu_result, rb_data;
    logic               branch_taken;
    logic               rf_we, retire, halted;
    logic [31:0]        rf_wdata, pc;

    always #5 clk = ~clk;

    core_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .instr(instr),
        .dec_wb(dec_wb), .dec_mem(dec_mem), .dec_mem_read(dec_mem_read),
        .dec_branch(dec_branch), .dec_illegal(dec_illegal), .imm(imm),
        .alu_result(alu_result), .rb_data(rb_data), .branch_taken(branch_taken),
        .rf_we(rf_we), .rf_wdata(rf_wdata), .pc(pc), .retire(retire), .halted(halted)
    );

    localparam logic [31:0] I_ADD  = 32'h0020_81B3;
    localparam logic [31:0] I_LW   = 32'h0000_A283;
    localparam logic [31:0] I_SW   = 32'h0020_A023;
    localparam logic [31:0] I_BEQ  = 32'h0000_0063;
    localparam logic [31:0] I_ILL  = 32'hFFFF_FFFF;

    // Memory and per-PC datapath tables, written only by the stimulus process.
    logic [31:0] mem       [0:255];
    logic [31:0] imm_tab   [0:255];
    logic [31:0] alu_tab   [0:255];
    logic [31:0] rb_tab    [0:255];
    logic        taken_tab [0:255];
    int          fetch_waits = 0;
    int          data_waits  = 0;
    int          cur_waits;

    int          wcnt    = 0;
    int          cyc     = 0;
    int          st_cnt  = 0;
    logic [31:0] st_data = 32'd0;
    logic [31:0] st_addr = 32'd0;

    always_comb begin
        dec_wb = 1'b0; dec_mem = 1'b0; dec_mem_read = 1'b0; dec_branch = 1'b0; dec_illegal = 1'b0;
        case (instr[6:0])
            OP_OP, OP_OP_IMM, OP_LUI: dec_wb = 1'b1;
            OP_LOAD:   begin dec_wb = 1'b1; dec_mem = 1'b1; dec_mem_read = 1'b1; end
            OP_STORE:  dec_mem = 1'b1;
            OP_BRANCH: dec_branch = 1'b1;
            default:   dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        imm          = imm_tab[pc[9:2]];
        alu_result   = alu_tab[pc[9:2]];
        rb_data      = rb_tab[pc[9:2]];
        branch_taken = taken_tab[pc[9:2]];
        cur_waits    = (mem_addr >= 32'h100) ? data_waits : fetch_waits;
        mem_ready    = mem_req && (wcnt >= cur_waits);
        mem_rdata    = mem[mem_addr[9:2]];
    end

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
        if (mem_req && !mem_ready) wcnt <= wcnt + 1;
        else                       wcnt <= 0;
        if (mem_req && mem_we && mem_ready) begin
            st_cnt  <= st_cnt + 1;
            st_data <= mem_wdata;
            st_addr <= mem_addr;
        end
    end

    // Scoreboard: expected memory transactions / retirements, plus direct checks.
    typedef struct {
        bit          is_ret;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
        bit          rf_we;
        logic [31:0] rf_wdata;
    } ev_t;
    typedef struct {
        int          kind;
        logic [31:0] exp;
    } dchk_t;

    localparam int K_PC = 0, K_INSTR = 1, K_HALTED = 2, K_MEMREQ = 3, K_RFWE = 4, K_RETIRE = 5,
                   K_MEMADDR = 6, K_RFWDATA = 7, K_STCNT = 8, K_STDATA = 9, K_STADDR = 10,
                   K_QEMPTY = 11, K_MEMWE = 12;

    ev_t   q  [$];
    dchk_t dq [$];
    int    n_cmp = 0;
    int    n_err = 0;
    bit    mon_en = 1'b0;
    bit    prev_wait = 1'b0;
    logic        prev_we = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    logic [31:0] prev_wdata = 32'd0;
    dchk_t d_cur;

    function automatic string kname(input int k);
        case (k)
            K_PC: return "pc";           K_INSTR: return "instr";
            K_HALTED: return "halted";   K_MEMREQ: return "mem_req";
            K_RFWE: return "rf_we";      K_RETIRE: return "retire";
            K_MEMADDR: return "mem_addr"; K_RFWDATA: return "rf_wdata";
            K_STCNT: return "store_count"; K_STDATA: return "store_data";
            K_STADDR: return "store_addr"; K_QEMPTY: return "pending_events";
            K_MEMWE: return "mem_we";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic [31:0] kval(input int k);
        case (k)
            K_PC: return pc;
            K_INSTR: return instr;
            K_HALTED: return {31'd0, halted};
            K_MEMREQ: return {31'd0, mem_req};
            K_RFWE: return {31'd0, rf_we};
            K_RETIRE: return {31'd0, retire};
            K_MEMADDR: return mem_addr;
            K_RFWDATA: return rf_wdata;
            K_STCNT: return 32'(st_cnt);
            K_STDATA: return st_data;
            K_STADDR: return st_addr;
            K_QEMPTY: return 32'(q.size());
            K_MEMWE: return {31'd0, mem_we};
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic run_dchk(input dchk_t d);
        logic [31:0] act;
        act = kval(d.kind);
        n_cmp++;
        if (act !== d.exp) begin
            n_err++;
            $display("FAIL %s at cyc %0d: got %h, expected %h", kname(d.kind), cyc, act, d.exp);
            if (d.kind == K_QEMPTY) q.delete();
        end
    endtask

    task automatic check_ev(input bit is_ret);
        ev_t e;
        bit  ok;
        n_cmp++;
        if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_%s at cyc %0d: got addr %h, expected no event",
                     is_ret ? "retire" : "mem_txn", cyc, mem_addr);
            return;
        end
        e = q.pop_front();
        if (is_ret) begin
            ok = e.is_ret && (cyc == e.cyc) && (rf_we == e.rf_we) && (!e.rf_we || rf_wdata == e.rf_wdata);
            if (!ok) begin
                n_err++;
                $display("FAIL retire: got cyc=%0d rf_we=%0b rf_wdata=%h, expected ret=%0b cyc=%0d rf_we=%0b rf_wdata=%h",
                         cyc, rf_we, rf_wdata, e.is_ret, e.cyc, e.rf_we, e.rf_wdata);
            end
        end else begin
            ok = !e.is_ret && (cyc == e.cyc) && (mem_we == e.we) && (mem_addr == e.addr) &&
                 (!e.we || mem_wdata == e.wdata);
            if (!ok) begin
                n_err++;
                $display("FAIL mem_txn: got cyc=%0d we=%0b addr=%h wdata=%h, expected ret=%0b cyc=%0d we=%0b addr=%h wdata=%h",
                         cyc, mem_we, mem_addr, mem_wdata, e.is_ret, e.cyc, e.we, e.addr, e.wdata);
            end
        end
    endtask

    always @(negedge clk) begin
        while (dq.size() > 0) begin
            d_cur = dq.pop_front();
            run_dchk(d_cur);
        end
        if (mon_en) begin
            if (mem_req && mem_ready) check_ev(1'b0);
            if (retire) check_ev(1'b1);
            if (rf_we && !retire) begin
                n_cmp++; n_err++;
                $display("FAIL rf_we_outside_retire at cyc %0d: got rf_we=1, expected 0", cyc);
            end
            if (prev_wait && mem_req) begin
                n_cmp++;
                if (mem_addr !== prev_addr || mem_we !== prev_we || (mem_we && mem_wdata !== prev_wdata)) begin
                    n_err++;
                    $display("FAIL hold_stable at cyc %0d: got we=%0b addr=%h wdata=%h, expected we=%0b addr=%h wdata=%h",
                             cyc, mem_we, mem_addr, mem_wdata, prev_we, prev_addr, prev_wdata);
                end
            end
            prev_wait  <= mem_req && !mem_ready;
            prev_we    <= mem_we;
            prev_addr  <= mem_addr;
            prev_wdata <= mem_wdata;
        end else begin
            prev_wait <= 1'b0;
        end
    end

    task automatic chk(input int k, input logic [31:0] v);
        dchk_t d;
        d.kind = k; d.exp = v;
        dq.push_back(d);
    endtask

    task automatic exp_txn(input bit we, input logic [31:0] a, input logic [31:0] wd, input int c);
        ev_t e;
        e.is_ret = 1'b0; e.we = we; e.addr = a; e.wdata = wd; e.cyc = c; e.rf_we = 1'b0; e.rf_wdata = 32'd0;
        q.push_back(e);
    endtask

    task automatic exp_ret(input int c, input bit w, input logic [31:0] wd);
        ev_t e;
        e.is_ret = 1'b1; e.we = 1'b0; e.addr = 32'd0; e.wdata = 32'd0; e.cyc = c; e.rf_we = w; e.rf_wdata = wd;
        q.push_back(e);
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 256; i++) begin
            mem[i] = NOP; imm_tab[i] = 32'd0; alu_tab[i] = 32'd0; rb_tab[i] = 32'd0; taken_tab[i] = 1'b0;
        end
        fetch_waits = 0;
        data_waits  = 0;
    endtask

    // Called at posedge+1; leaves rst high with registers already reset.
    task automatic rst_assert();
        mon_en = 1'b0;
        rst    = 1'b1;
        chk(K_MEMREQ, 32'd0); chk(K_RFWE, 32'd0); chk(K_RETIRE, 32'd0);
        @(posedge clk); #1;
        chk(K_PC, 32'd0); chk(K_INSTR, NOP); chk(K_HALTED, 32'd0);
        chk(K_MEMADDR, 32'd0); chk(K_RFWDATA, 32'd0); chk(K_MEMREQ, 32'd0);
    endtask

    task automatic rst_release();
        @(negedge clk);
        @(posedge clk); #1;
        q.delete();
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while (q.size() != 0 && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        chk(K_QEMPTY, 32'd0);
    endtask

    int st_before;

    initial begin
        clear_tables();
        rst_assert();

        // ALU op, zero-wait
        mem[0] = I_ADD; alu_tab[0] = 32'h0000_0055;
        rst_release();
        exp_txn(1'b0, 32'h0, 32'h0, 0); exp_ret(3, 1'b1, 32'h55); exp_txn(1'b0, 32'h4, 32'h0, 4);
        wait_drain(30);
        chk(K_PC, 32'h4);

        // Load with two wait states on fetch and data
        rst_assert();
        clear_tables();
        mem[0] = I_LW; alu_tab[0] = 32'h200; mem[128] = 32'hDEAD_BEEF;
        fetch_waits = 2; data_waits = 2;
        rst_release();
        exp_txn(1'b0, 32'h0, 32'h0, 2); exp_txn(1'b0, 32'h200, 32'h0, 7);
        exp_ret(8, 1'b1, 32'hDEAD_BEEF); exp_txn(1'b0, 32'h4, 32'h0, 11);
        wait_drain(40);
        chk(K_PC, 32'h4);

        // Store, zero-wait
        rst_assert();
        clear_tables();
        mem[0] = I_SW; alu_tab[0] = 32'h100; rb_tab[0] = 32'h1234_5678;
        st_before = st_cnt;
        rst_release();
        exp_txn(1'b0, 32'h0, 32'h0, 0); exp_txn(1'b1, 32'h100, 32'h1234_5678, 3);
        exp_ret(3, 1'b0, 32'h0); exp_txn(1'b0, 32'h4, 32'h0, 4);
        wait_drain(30);
        chk(K_PC, 32'h4); chk(K_STCNT, 32'(st_before + 1));
        chk(K_STDATA, 32'h1234_5678); chk(K_STADDR, 32'h100);

        // Branch from 0x40 back by 8, taken then not taken
        for (int t = 0; t < 2; t++) begin
            rst_assert();
            clear_tables();
            mem[0] = I_BEQ; imm_tab[0] = 32'h40; taken_tab[0] = 1'b1;
            mem[16] = I_BEQ; imm_tab[16] = 32'hFFFF_FFF8; taken_tab[16] = (t == 0);
            rst_release();
            exp_txn(1'b0, 32'h0, 32'h0, 0); exp_ret(2, 1'b0, 32'h0);
            exp_txn(1'b0, 32'h40, 32'h0, 3); exp_ret(5, 1'b0, 32'h0);
            exp_txn(1'b0, (t == 0) ? 32'h38 : 32'h44, 32'h0, 6);
            wait_drain(30);
            chk(K_PC, (t == 0) ? 32'h38 : 32'h44);
        end

        // Misaligned branch target halts with PC held
        rst_assert();
        clear_tables();
        mem[0] = I_BEQ; imm_tab[0] = 32'h40; taken_tab[0] = 1'b1;
        mem[16] = I_BEQ; imm_tab[16] = 32'h2; taken_tab[16] = 1'b1;
        rst_release();
        exp_txn(1'b0, 32'h0, 32'h0, 0); exp_ret(2, 1'b0, 32'h0); exp_txn(1'b0, 32'h40, 32'h0, 3);
        wait_drain(30);
        repeat (8) begin @(posedge clk); #1; end
        chk(K_HALTED, 32'd1); chk(K_PC, 32'h40); chk(K_MEMREQ, 32'd0);

        // Illegal instruction halts; reset recovers and refetches at RESET_PC
        rst_assert();
        clear_tables();
        mem[0] = I_ILL;
        rst_release();
        exp_txn(1'b0, 32'h0, 32'h0, 0);
        wait_drain(30);
        repeat (6) begin @(posedge clk); #1; end
        chk(K_HALTED, 32'd1); chk(K_PC, 32'h0); chk(K_MEMREQ, 32'd0);
        rst_assert();
        clear_tables();
        mem[0] = I_ADD; alu_tab[0] = 32'h0000_0077;
        rst_release();
        exp_txn(1'b0, 32'h0, 32'h0, 0); exp_ret(3, 1'b1, 32'h77); exp_txn(1'b0, 32'h4, 32'h0, 4);
        wait_drain(30);

        // Reset during a stalled store: request dropped, no write lands
        rst_assert();
        clear_tables();
        mem[0] = I_SW; alu_tab[0] = 32'h100; rb_tab[0] = 32'hA5A5_A5A5;
        data_waits = 1000;
        rst_release();
        exp_txn(1'b0, 32'h0, 32'h0, 0);
        wait_drain(30);
        repeat (3) begin @(posedge clk); #1; end
        chk(K_MEMREQ, 32'd1); chk(K_MEMWE, 32'd1); chk(K_MEMADDR, 32'h100);
        @(posedge clk); #1;
        st_before = st_cnt;
        rst_assert();
        clear_tables();
        mem[0] = I_ADD; alu_tab[0] = 32'h0000_0055;
        rst_release();
        exp_txn(1'b0, 32'h0, 32'h0, 0); exp_ret(3, 1'b1, 32'h55); exp_txn(1'b0, 32'h4, 32'h0, 4);
        wait_drain(30);
        chk(K_STCNT, 32'(st_before));

        rst_assert();
        repeat (2) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
